// File: rtl/up_down_count_monitor.sv
// up_down_count_monitor
// Passive checker that sits beside an up/down counter. It samples the
// count/mode interface on every clock and predicts each count from the one
// sampled on the edge before. It flags mismatches, correct wraps and the
// observed direction. It also keeps a saturating error count and goes into a
// sticky FAULT state once that count reaches ERR_LIMIT.
module up_down_count_monitor #(
    parameter int WIDTH     = 4,
    parameter int ERR_W     = 8,
    parameter int ERR_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_rst,
    input  logic             mode,
    input  logic [WIDTH-1:0] count,
    input  logic             clr_err,
    output logic             locked,
    output logic             dir_up,
    output logic             mismatch,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count,
    output logic             fault
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_LIM_V = ERR_W'(ERR_LIMIT);
    localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_count_q, prev_count_d;
    logic             prev_mode_q, prev_mode_d;
    // primed_q: prev_* holds a sample that the next count can be judged against.
    // It stays 0 on the first edge after cnt_rst falls, including in FAULT.
    logic             primed_q, primed_d;
    logic             locked_q, locked_d;
    logic             dir_up_q, dir_up_d;
    logic             mismatch_q, mismatch_d;
    logic             wrap_q, wrap_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             fault_q, fault_d;

    logic [WIDTH-1:0] expected;
    logic [ERR_W-1:0] err_inc;
    logic             do_check;
    logic             at_boundary;

    // Next-state logic: prediction, comparison, error accounting and FSM moves.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        prev_count_d = count;
        prev_mode_d  = mode;
        primed_d     = primed_q;
        dir_up_d     = dir_up_q;
        mismatch_d   = 1'b0;
        wrap_d       = 1'b0;
        err_count_d  = err_count_q;

        expected    = prev_mode_q ? (prev_count_q + CNT_ONE) : (prev_count_q - CNT_ONE);
        at_boundary = prev_mode_q ? (prev_count_q == CNT_MAX) : (prev_count_q == '0);
        err_inc     = (err_count_q == ERR_MAX) ? err_count_q : (err_count_q + ERR_W'(1));
        do_check    = (state_q != SYNC) && primed_q && !cnt_rst && !clr_err;

        if (do_check) begin
            if (count == expected) begin
                dir_up_d = prev_mode_q;
                wrap_d   = at_boundary;
            end else begin
                mismatch_d  = 1'b1;
                err_count_d = err_inc;
                if (state_q == TRACK && err_inc >= ERR_LIM_V) begin
                    state_d = FAULT;
                end
            end
        end

        if (clr_err) begin
            err_count_d = '0;
            state_d     = SYNC;
            primed_d    = 1'b0;
        end else if (cnt_rst) begin
            primed_d = 1'b0;
            if (state_q != FAULT) begin
                state_d = SYNC;
            end
        end else begin
            primed_d = 1'b1;
            if (state_q == SYNC) begin
                state_d = TRACK;
            end
        end

        locked_d = (state_d != SYNC);
        fault_d  = (state_d == FAULT);
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SYNC;
            prev_count_q <= '0;
            prev_mode_q  <= 1'b0;
            primed_q     <= 1'b0;
            locked_q     <= 1'b0;
            dir_up_q     <= 1'b0;
            mismatch_q   <= 1'b0;
            wrap_q       <= 1'b0;
            err_count_q  <= '0;
            fault_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register updates from pre-edge values.
            state_q      <= state_d;
            prev_count_q <= prev_count_d;
            prev_mode_q  <= prev_mode_d;
            primed_q     <= primed_d;
            locked_q     <= locked_d;
            dir_up_q     <= dir_up_d;
            mismatch_q   <= mismatch_d;
            wrap_q       <= wrap_d;
            err_count_q  <= err_count_d;
            fault_q      <= fault_d;
        end
    end

    assign locked    = locked_q;
    assign dir_up    = dir_up_q;
    assign mismatch  = mismatch_q;
    assign wrap      = wrap_q;
    assign err_count = err_count_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_up_down_count_monitor.sv
// Testbench for up_down_count_monitor. It drives a software counter through
// directed scenarios and then a random phase, and compares every registered
// output against a behavioural model after each clock edge.
module tb_up_down_count_monitor;

    logic       clk = 1'b1;
    logic       rst = 1'b1;
    logic       cnt_rst = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] count = 4'd0;
    logic       clr_err = 1'b0;
    logic       locked, dir_up, mismatch, wrap, fault;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    // The software counter whose value is presented on count.
    logic [3:0] sw = 4'd0;

    // Behavioural model state.
    bit m_locked, m_armed, m_fault, m_dir, m_mis, m_wrap;
    int m_err;
    int ref_cnt;
    bit ref_mode;

    up_down_count_monitor #(.WIDTH(4), .ERR_W(8), .ERR_LIMIT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_rst   (cnt_rst),
        .mode      (mode),
        .count     (count),
        .clr_err   (clr_err),
        .locked    (locked),
        .dir_up    (dir_up),
        .mismatch  (mismatch),
        .wrap      (wrap),
        .err_count (err_count),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_armed = 0; m_fault = 0; m_dir = 0; m_mis = 0; m_wrap = 0;
        m_err = 0; ref_cnt = 0; ref_mode = 0;
    endtask

    // One clock edge of the monitor's intended behaviour, based on the inputs present at that edge.
    task automatic model_edge();
        bit do_chk;
        int exp_c;
        do_chk = m_locked && m_armed && !cnt_rst && !clr_err;
        m_mis  = 0;
        m_wrap = 0;
        if (do_chk) begin
            exp_c = ref_mode ? (ref_cnt + 1) % 16 : (ref_cnt + 15) % 16;
            if (int'(count) == exp_c) begin
                m_dir  = ref_mode;
                m_wrap = ref_mode ? (ref_cnt == 15) : (ref_cnt == 0);
            end else begin
                m_mis = 1;
                if (m_err < 255) m_err++;
                if (m_err >= 3) m_fault = 1;
            end
        end
        if (clr_err) begin
            m_err = 0; m_fault = 0; m_locked = 0; m_armed = 0;
        end else if (cnt_rst) begin
            m_armed = 0;
            if (!m_fault) m_locked = 0;
        end else begin
            m_locked = 1; m_armed = 1;
        end
        ref_cnt  = int'(count);
        ref_mode = mode;
    endtask

    // Present one sample, let the edge pass, advance the software counter and compare.
    task automatic run(input bit md, input bit cr = 1'b0, input bit ce = 1'b0, input bit glitch = 1'b0);
        if (glitch) sw = sw + 4'd2;
        mode    = md;
        cnt_rst = cr;
        clr_err = ce;
        count   = sw;
        @(posedge clk);
        model_edge();
        sw = cr ? 4'd0 : (md ? sw + 4'd1 : sw - 4'd1);
        #1;
        check("locked",    locked,    32'(m_locked));
        check("dir_up",    dir_up,    32'(m_dir));
        check("mismatch",  mismatch,  32'(m_mis));
        check("wrap",      wrap,      32'(m_wrap));
        check("err_count", err_count, 32'(m_err));
        check("fault",     fault,     32'(m_fault));
        check("mis_wrap_exclusive", 32'(mismatch & wrap), 32'd0);
    endtask

    int wraps_seen;

    initial begin
        model_reset();
        #2;
        check("rst_locked",   locked,    0);
        check("rst_dir_up",   dir_up,    0);
        check("rst_mismatch", mismatch,  0);
        check("rst_wrap",     wrap,      0);
        check("rst_err",      err_count, 0);
        check("rst_fault",    fault,     0);
        #13 rst = 1'b0;

        // Count up through the 15 -> 0 wrap.
        sw = 4'd0;
        wraps_seen = 0;
        for (int i = 0; i < 20; i++) begin
            run(1'b1);
            if (wrap) wraps_seen++;
        end
        check("up_wraps_seen",  wraps_seen, 1);
        check("up_err",         err_count,  0);
        check("up_dir",         dir_up,     1);
        check("up_locked",      locked,     1);

        // Count down through the 0 -> 15 wrap.
        wraps_seen = 0;
        for (int i = 0; i < 20; i++) begin
            run(1'b0);
            if (wrap) wraps_seen++;
        end
        check("down_wraps_seen", wraps_seen, 1);
        check("down_err",        err_count,  0);
        check("down_dir",        dir_up,     0);

        // A single glitch, after which checking stays clean.
        run(1'b1);
        run(1'b1, 1'b0, 1'b0, 1'b1);
        check("glitch1_mismatch", mismatch,  1);
        check("glitch1_err",      err_count, 1);
        run(1'b1);
        check("after_glitch_clean", mismatch, 0);
        check("after_glitch_err",   err_count, 1);

        // Two more glitches push the monitor into FAULT.
        run(1'b1, 1'b0, 1'b0, 1'b1);
        run(1'b1);
        run(1'b1, 1'b0, 1'b0, 1'b1);
        check("fault_err",    err_count, 3);
        check("fault_flag",   fault,     1);
        check("fault_locked", locked,    1);

        // clr_err returns the monitor to SYNC, then it relocks.
        run(1'b1, 1'b0, 1'b1);
        check("clr_err_count",  err_count, 0);
        check("clr_fault",      fault,     0);
        check("clr_locked",     locked,    0);
        run(1'b1);
        check("relock", locked, 1);
        repeat (3) run(1'b1);

        // cnt_rst pulse in the middle of counting.
        run(1'b1, 1'b1);
        check("cnt_rst_unlock", locked, 0);
        run(1'b1);
        check("cnt_rst_relock", locked, 1);
        repeat (4) run(1'b1);
        check("cnt_rst_err", err_count, 0);

        // Toggle mode on every clock, so the count goes back and forth.
        run(1'b1);
        run(1'b0);
        check("toggle_dir_a", dir_up, 1);
        run(1'b1);
        check("toggle_dir_b", dir_up, 0);
        run(1'b0);
        check("toggle_dir_c", dir_up, 1);
        check("toggle_err",   err_count, 0);

        // Push into FAULT again, then assert rst between clock edges.
        run(1'b1, 1'b0, 1'b0, 1'b1);
        run(1'b1, 1'b0, 1'b0, 1'b1);
        run(1'b1, 1'b0, 1'b0, 1'b1);
        check("pre_rst_fault", fault, 1);
        #2 rst = 1'b1;
        #1;
        check("async_locked",   locked,    0);
        check("async_dir_up",   dir_up,    0);
        check("async_mismatch", mismatch,  0);
        check("async_wrap",     wrap,      0);
        check("async_err",      err_count, 0);
        check("async_fault",    fault,     0);
        model_reset();
        @(negedge clk) rst = 1'b0;
        sw = 4'd0;

        // Random phase: mode, glitches, cnt_rst and clr_err all mixed.
        for (int i = 0; i < 400; i++) begin
            run(1'($urandom_range(0, 1)),
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 29) == 0,
                $urandom_range(0, 11) == 0);
        end

        cnt_rst = 1'b0;
        clr_err = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
